// File: rtl/vr_pipe_slice_pkg.sv
// Shared handshake definitions for the valid/ready pipeline slice chain:
// per-stage mode encodings and a width helper for the occupancy counter.
package handshake_pkg;

    localparam int MODE_BYPASS = 0;
    localparam int MODE_FWD    = 1;
    localparam int MODE_BWD    = 2;
    localparam int MODE_FULL   = 3;

    // Bits needed to hold the values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vr_pipe_slice_if.sv
// Valid/ready payload channel. The master drives valid/data, the slave
// drives ready; a transfer happens on a rising edge with valid && ready.
interface vr_pipe_slice_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_pipe_slice_stage.sv
// One valid/ready slice stage. MODE selects bypass wires, a forward
// register, a backward skid register, or a fully registered two-entry
// buffer. flush clears held entries on the next edge and blocks both
// handshakes while it is high. cnt reports the entries currently held.
module vr_slice_stage
    import handshake_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       cnt
);

    if (MODE == MODE_BYPASS) begin : g_bypass
        // Pure wires: no storage, so the clock and reset have nothing to drive.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n};

        assign in_ready  = out_ready & ~flush;
        assign out_valid = in_valid & ~flush;
        assign out_data  = in_data;
        assign cnt       = 2'd0;

    end else if (MODE == MODE_FWD) begin : g_fwd
        logic             vld_p0;
        logic [WIDTH-1:0] dat_p0;
        logic             load;

        // The slot may reload whenever it is empty or being emptied this cycle.
        assign load      = ~vld_p0 | out_ready;
        assign in_ready  = load & ~flush;
        assign out_valid = vld_p0 & ~flush;
        assign out_data  = dat_p0;
        assign cnt       = {1'b0, vld_p0};

        // Output register: refill from the input whenever the slot frees up.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                dat_p0 <= '0;
            end else if (flush) begin
                vld_p0 <= 1'b0;
            end else if (load) begin
                vld_p0 <= in_valid;
                if (in_valid) begin
                    dat_p0 <= in_data;
                end
            end
        end

    end else if (MODE == MODE_BWD) begin : g_bwd
        logic             vld_p0;
        logic [WIDTH-1:0] dat_p0;

        // Ready comes straight from the skid flag, cutting the ready path.
        assign in_ready  = ~vld_p0 & ~flush;
        assign out_valid = (in_valid | vld_p0) & ~flush;
        assign out_data  = vld_p0 ? dat_p0 : in_data;
        assign cnt       = {1'b0, vld_p0};

        // Skid register: catch an accepted word the downstream refused, release it once ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                dat_p0 <= '0;
            end else if (flush) begin
                vld_p0 <= 1'b0;
            end else if (vld_p0) begin
                if (out_ready) begin
                    vld_p0 <= 1'b0;
                end
            end else if (in_valid && !out_ready) begin
                vld_p0 <= 1'b1;
                dat_p0 <= in_data;
            end
        end

    end else begin : g_full
        // Main entry (p0) feeds the output; the skid entry (p1) absorbs the
        // word accepted while the main entry is stalled.
        logic             vld_p0;
        logic [WIDTH-1:0] dat_p0;
        logic             vld_p1;
        logic [WIDTH-1:0] dat_p1;
        logic             push;
        logic             pop;

        assign in_ready  = ~vld_p1 & ~flush;
        assign out_valid = vld_p0 & ~flush;
        assign out_data  = dat_p0;
        assign push      = in_valid & ~vld_p1;
        assign pop       = vld_p0 & out_ready;
        assign cnt       = {vld_p0 & vld_p1, vld_p0 ^ vld_p1};

        // Two-entry buffer: output only from registers, skid refills main on pop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                dat_p0 <= '0;
                vld_p1 <= 1'b0;
                dat_p1 <= '0;
            end else if (flush) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else if (!vld_p0) begin
                if (push) begin
                    vld_p0 <= 1'b1;
                    dat_p0 <= in_data;
                end
            end else if (pop) begin
                if (vld_p1) begin
                    dat_p0 <= dat_p1;
                    vld_p1 <= 1'b0;
                end else if (push) begin
                    dat_p0 <= in_data;
                end else begin
                    vld_p0 <= 1'b0;
                end
            end else if (push) begin
                vld_p1 <= 1'b1;
                dat_p1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/vr_pipe_slice.sv
// Cascade of STAGES identical valid/ready slice stages between an upstream
// (m_if) and a downstream (s_if) channel, with a registered count of the
// entries held anywhere in the chain and a synchronous flush.
module vr_pipe_slice
    import handshake_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int MODE   = 3,
    localparam int OCC_W = clog2(2 * STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    vr_pipe_slice_if.slave       m_if,
    vr_pipe_slice_if.master      s_if,
    output logic [OCC_W-1:0]     occupancy
);

    logic [2*STAGES-1:0] cnt_all;
    logic [OCC_W-1:0]    occ_sum;

    genvar i;
    for (i = 0; i < STAGES; i++) begin : g_stg
        logic             in_valid;
        logic             in_ready;
        logic [WIDTH-1:0] in_data;
        logic             out_valid;
        logic             out_ready;
        logic [WIDTH-1:0] out_data;
        logic [1:0]       cnt;

        if (i == 0) begin : g_head
            assign in_valid = m_if.valid;
            assign in_data  = m_if.data;
        end else begin : g_link_in
            assign in_valid = g_stg[i-1].out_valid;
            assign in_data  = g_stg[i-1].out_data;
        end

        if (i == STAGES - 1) begin : g_tail
            assign out_ready = s_if.ready;
        end else begin : g_link_out
            assign out_ready = g_stg[i+1].in_ready;
        end

        assign cnt_all[2*i +: 2] = cnt;

        vr_slice_stage #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .cnt       (cnt)
        );
    end

    assign m_if.ready = g_stg[0].in_ready;
    assign s_if.valid = g_stg[STAGES-1].out_valid;
    assign s_if.data  = g_stg[STAGES-1].out_data;

    // Add up the per-stage entry counts.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_sum = occ_sum + OCC_W'(cnt_all[2*k +: 2]);
        end
    end

    // Occupancy register; flush forces zero so it reads 0 right after the flush edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_sum;
        end
    end

endmodule

// File: tb/tb_vr_pipe_slice.sv
// Directed bench for vr_pipe_slice: one instance per mode/depth combination,
// driven one at a time with hand-computed expected values.
module tb_vr_pipe_slice;

    logic clk;
    logic rst_n;
    logic flush;

    int checks;
    int failures;

    vr_pipe_slice_if #(.WIDTH(8)) a_m ();
    vr_pipe_slice_if #(.WIDTH(8)) a_s ();
    vr_pipe_slice_if #(.WIDTH(8)) b_m ();
    vr_pipe_slice_if #(.WIDTH(8)) b_s ();
    vr_pipe_slice_if #(.WIDTH(8)) c_m ();
    vr_pipe_slice_if #(.WIDTH(8)) c_s ();
    vr_pipe_slice_if #(.WIDTH(8)) d_m ();
    vr_pipe_slice_if #(.WIDTH(8)) d_s ();
    vr_pipe_slice_if #(.WIDTH(8)) e_m ();
    vr_pipe_slice_if #(.WIDTH(8)) e_s ();

    logic [2:0] occ_a;
    logic [2:0] occ_b;
    logic [1:0] occ_c;
    logic [2:0] occ_d;
    logic [2:0] occ_e;

    vr_pipe_slice #(.WIDTH(8), .STAGES(2), .MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .m_if(a_m), .s_if(a_s), .occupancy(occ_a));
    vr_pipe_slice #(.WIDTH(8), .STAGES(2), .MODE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .m_if(b_m), .s_if(b_s), .occupancy(occ_b));
    vr_pipe_slice #(.WIDTH(8), .STAGES(1), .MODE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .m_if(c_m), .s_if(c_s), .occupancy(occ_c));
    vr_pipe_slice #(.WIDTH(8), .STAGES(3), .MODE(3)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(flush), .m_if(d_m), .s_if(d_s), .occupancy(occ_d));
    vr_pipe_slice #(.WIDTH(8), .STAGES(2), .MODE(0)) u_e (
        .clk(clk), .rst_n(rst_n), .flush(flush), .m_if(e_m), .s_if(e_s), .occupancy(occ_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int nrx;
        logic [7:0] rx [0:15];
        logic [7:0] pv_d [0:2];
        logic [7:0] pv_m [0:2];
        logic       pv_v [0:2];
        logic       pv_r [0:2];

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        a_m.valid = 1'b0; a_m.data = '0; a_s.ready = 1'b0;
        b_m.valid = 1'b0; b_m.data = '0; b_s.ready = 1'b0;
        c_m.valid = 1'b0; c_m.data = '0; c_s.ready = 1'b0;
        d_m.valid = 1'b0; d_m.data = '0; d_s.ready = 1'b0;
        e_m.valid = 1'b0; e_m.data = '0; e_s.ready = 1'b0;

        // Reset state
        repeat (3) step();
        settle();
        check("rst_s_valid_a", a_s.valid, 0);
        check("rst_occ_a", occ_a, 0);
        check("rst_s_valid_b", b_s.valid, 0);
        check("rst_occ_b", occ_b, 0);
        check("rst_s_valid_d", d_s.valid, 0);
        step();
        rst_n = 1'b1;
        settle();
        check("rst_m_ready_a", a_m.ready, 1);
        check("rst_m_ready_b", b_m.ready, 1);
        check("rst_m_ready_c", c_m.ready, 1);
        check("rst_m_ready_d", d_m.ready, 1);

        // Test 1: forward mode, free-flowing stream, latency 2
        a_s.ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            a_m.valid = (c < 16);
            a_m.data  = 8'(c + 1);
            settle();
            if (c < 16) check("t1_m_ready", a_m.ready, 1);
            if (c < 2) begin
                check("t1_s_valid_early", a_s.valid, 0);
            end else begin
                check("t1_s_valid", a_s.valid, 1);
                check("t1_s_data", a_s.data, 32'(c - 1));
            end
        end
        step();
        a_m.valid = 1'b0;
        repeat (3) step();

        // Test 2: full mode fills to 4, then drains in order
        acc = 0;
        nrx = 0;
        for (int c = 0; c < 22; c++) begin
            step();
            b_s.ready = (c >= 8);
            b_m.valid = (acc < 6);
            b_m.data  = 8'(8'hA0 + acc);
            settle();
            if (c == 3) check("t2_s_data_hold3", b_s.data, 32'hA0);
            if (c == 7) begin
                check("t2_accepted", 32'(acc), 4);
                check("t2_m_ready_full", b_m.ready, 0);
                check("t2_s_valid", b_s.valid, 1);
                check("t2_s_data_hold7", b_s.data, 32'hA0);
                check("t2_occ_full", occ_b, 4);
            end
            if (b_s.valid && b_s.ready && nrx < 16) begin
                rx[nrx] = b_s.data;
                nrx++;
            end
            if (b_m.valid && b_m.ready) acc++;
        end
        check("t2_rx_count", 32'(nrx), 6);
        for (int k = 0; k < 6; k++) check("t2_rx_order", rx[k], 32'(8'hA0 + k));
        step();
        b_m.valid = 1'b0;

        // Test 3: backward mode with alternating downstream stalls
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            c_s.ready = (k % 2 == 0);
            c_m.valid = 1'b1;
            c_m.data  = 8'(8'h10 + acc);
            settle();
            check("t3_s_valid", c_s.valid, 1);
            check("t3_s_data", c_s.data, 32'(8'h10 + (k + 1) / 2));
            check("t3_m_ready", c_m.ready, ((k == 0) || (k % 2 == 1)) ? 1 : 0);
            if (k == 3) check("t3_occ_skid", occ_c, 1);
            if (c_m.valid && c_m.ready) acc++;
        end
        step();
        c_m.valid = 1'b0;
        c_s.ready = 1'b1;
        repeat (3) step();

        // Test 4: flush with 3 entries held and a concurrent offer on both sides
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            d_s.ready = 1'b0;
            d_m.valid = (acc < 3);
            d_m.data  = 8'(8'hB0 + acc);
            settle();
            if (d_m.valid && d_m.ready) acc++;
        end
        check("t4_occ_held", occ_d, 3);
        step();
        flush     = 1'b1;
        d_m.valid = 1'b1;
        d_m.data  = 8'hCC;
        d_s.ready = 1'b1;
        settle();
        check("t4_flush_m_ready", d_m.ready, 0);
        check("t4_flush_s_valid", d_s.valid, 0);
        step();
        flush     = 1'b0;
        d_m.valid = 1'b0;
        settle();
        check("t4_post_occ", occ_d, 0);
        check("t4_post_s_valid", d_s.valid, 0);
        check("t4_post_m_ready", d_m.ready, 1);
        step();
        settle();
        check("t4_post_occ2", occ_d, 0);

        // Test 5: asynchronous reset mid-operation, then restart
        acc = 0;
        a_s.ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            a_m.valid = (acc < 2);
            a_m.data  = 8'(8'h30 + acc);
            settle();
            if (a_m.valid && a_m.ready) acc++;
        end
        check("t5_occ_before", occ_a, 2);
        check("t5_s_data_before", a_s.data, 32'h30);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_s_valid", a_s.valid, 0);
        check("t5_rst_occ", occ_a, 0);
        step();
        rst_n = 1'b1;
        a_s.ready = 1'b1;
        settle();
        step();
        a_m.valid = 1'b1;
        a_m.data  = 8'h55;
        settle();
        check("t5_m_ready", a_m.ready, 1);
        check("t5_lat0", a_s.valid, 0);
        step();
        a_m.valid = 1'b0;
        settle();
        check("t5_lat1", a_s.valid, 0);
        step();
        settle();
        check("t5_lat2_valid", a_s.valid, 1);
        check("t5_lat2_data", a_s.data, 32'h55);

        // Test 6: bypass mode is combinational
        pv_v[0] = 1'b1; pv_m[0] = 8'h3C; pv_r[0] = 1'b1;
        pv_v[1] = 1'b0; pv_m[1] = 8'hA5; pv_r[1] = 1'b1;
        pv_v[2] = 1'b1; pv_m[2] = 8'hFF; pv_r[2] = 1'b0;
        pv_d[0] = 8'h3C; pv_d[1] = 8'hA5; pv_d[2] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            step();
            e_m.valid = pv_v[p];
            e_m.data  = pv_m[p];
            e_s.ready = pv_r[p];
            #1;
            check("t6_s_valid", e_s.valid, pv_v[p]);
            check("t6_s_data", e_s.data, pv_d[p]);
            check("t6_m_ready", e_m.ready, pv_r[p]);
            settle();
            check("t6_occ", occ_e, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
